// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the NUM_REQ writeback sources / issue stage (master)
// and the register-file write-port arbiter (slave).
interface reg_wb_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int REG_SEL_W = 5,
  parameter int DATA_W    = 32
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*REG_SEL_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         issue_en;
  logic [REG_SEL_W-1:0]         issue_addr;
  logic                         wr_en;
  logic [REG_SEL_W-1:0]         wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic [2**REG_SEL_W-1:0]      busy;
  logic                         proto_err;

  modport master (
    output req_valid, req_addr, req_data, issue_en, issue_addr,
    input  req_ready, wr_en, wr_addr, wr_data, busy, proto_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, issue_en, issue_addr,
    output req_ready, wr_en, wr_addr, wr_data, busy, proto_err
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Define WB_ARB_RR_EN for round-robin grant; default is fixed priority (lowest index wins).
module reg_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int REG_SEL_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  reg_wb_arbiter_if.slave     bus
);
  localparam int NUM_REGS = 2**REG_SEL_W;
  localparam int IDX_W    = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   w_pick;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_xfer;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic [REG_SEL_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0]    w_gnt_data;
  logic [NUM_REGS-1:0]  w_busy_nxt;
  logic                 w_err_nxt;

  logic                 r_wr_en;
  logic [REG_SEL_W-1:0] r_wr_addr;
  logic [DATA_W-1:0]    r_wr_data;
  logic [NUM_REGS-1:0]  r_busy;
  logic                 r_proto_err;

`ifdef WB_ARB_RR_EN
  // r_rr_ptr is the index where the next search starts (one past the last grant).
  logic [IDX_W-1:0] r_rr_ptr;

  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input int start);
    logic [NUM_REQ-1:0] g;
    int idx;
    g = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = start + off;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (valid[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  assign w_pick = rr_pick(bus.req_valid, int'(r_rr_ptr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end
`else
  assign w_pick = bus.req_valid & (~bus.req_valid + NUM_REQ'(1));
`endif

  // The write port never back-pressures, so any valid request is granted.
  assign w_gnt  = rst ? '0 : w_pick;
  assign w_xfer = |w_gnt;

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_gnt_idx = IDX_W'(i);
    end
  end

  assign w_gnt_addr = bus.req_addr[int'(w_gnt_idx)*REG_SEL_W +: REG_SEL_W];
  assign w_gnt_data = bus.req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

  // Clear before set: an issue to the register being written this cycle re-arms it
  // without flagging an error, since the old write has just been consumed.
  always_comb begin
    w_busy_nxt = r_busy;
    w_err_nxt  = r_proto_err;
    if (w_xfer) w_busy_nxt[w_gnt_addr] = 1'b0;
    if (bus.issue_en && bus.issue_addr != '0) begin
      if (w_busy_nxt[bus.issue_addr]) w_err_nxt = 1'b1;
      w_busy_nxt[bus.issue_addr] = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_wr_en     <= w_xfer && (w_gnt_addr != '0);
      if (w_xfer) begin
        r_wr_addr <= w_gnt_addr;
        r_wr_data <= w_gnt_data;
      end
      r_busy      <= w_busy_nxt;
      r_proto_err <= w_err_nxt;
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = r_busy;
  assign bus.proto_err = r_proto_err;
endmodule
